regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: the ALU and the load/store unit (LSU).
- Tracks a per-register pending scoreboard so decode can stall on RAW hazards.
- Sits between execute/memory stages and the register file; drives its wr_enable/wr_address/wr_data/write_pattern inputs.

---
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/LSU writeback arbiter with RAW pending scoreboard
// Optional forwarding outputs enabled by REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_pattern,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
  output logic            rs1_fwd_hit,
  output logic            rs2_fwd_hit,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic            rf_wr_enable,
  output logic [4:0]      rf_wr_address,
  output logic [XLEN-1:0] rf_wr_data,
  output logic [2:0]      rf_write_pattern
);

  localparam logic [2:0] PAT_LBU = 3'b100;

  logic             rr_ptr;
  logic             grant_alu;
  logic             grant_lsu;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             rs1_pend;
  logic             rs2_pend;

  // No grants while reset is asserted, so nothing is handshaked away during reset.
  always_comb begin
    grant_alu = reset_n & alu_valid & (~lsu_valid | ~rr_ptr);
    grant_lsu = reset_n & lsu_valid & (~alu_valid |  rr_ptr);
  end

  assign alu_ready = alu_valid & grant_alu;
  assign lsu_ready = lsu_valid & grant_lsu;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr           <= 1'b0;
      rf_wr_enable     <= 1'b0;
      rf_wr_address    <= '0;
      rf_wr_data       <= '0;
      rf_write_pattern <= '0;
    end else if (grant_alu) begin
      rr_ptr           <= 1'b1;
      rf_wr_enable     <= (alu_rd != 5'd0);
      rf_wr_address    <= alu_rd;
      rf_wr_data       <= alu_data;
      rf_write_pattern <= 3'b000;
    end else if (grant_lsu) begin
      rr_ptr           <= 1'b0;
      rf_wr_enable     <= (lsu_rd != 5'd0);
      rf_wr_address    <= lsu_rd;
      rf_wr_data       <= lsu_data;
      rf_write_pattern <= lsu_pattern;
    end else begin
      rf_wr_enable     <= 1'b0;
    end
  end

  // Clear is applied before set so an issue landing on the commit edge keeps the bit.
  always_comb begin
    pending_next = pending;
    if (rf_wr_enable) pending_next[rf_wr_address] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_next;
  end

  assign rs1_pend = (rs1_addr != 5'd0) & pending[rs1_addr];
  assign rs2_pend = (rs2_addr != 5'd0) & pending[rs2_addr];

`ifdef REGFILE_WB_BYPASS_EN
  logic [XLEN-1:0] fwd_value;

  assign fwd_value = (rf_write_pattern == PAT_LBU) ? {{(XLEN-8){1'b0}}, rf_wr_data[7:0]}
                                                   : rf_wr_data;

  assign rs1_fwd_hit  = rf_wr_enable & (rf_wr_address == rs1_addr) & (rs1_addr != 5'd0);
  assign rs2_fwd_hit  = rf_wr_enable & (rf_wr_address == rs2_addr) & (rs2_addr != 5'd0);
  assign rs1_fwd_data = fwd_value;
  assign rs2_fwd_data = fwd_value;

  // A same-cycle re-issue of the register means a newer write is coming; keep stalling.
  assign rs1_busy = rs1_pend & ~(rs1_fwd_hit & ~(issue_valid & (issue_rd == rs1_addr)));
  assign rs2_busy = rs2_pend & ~(rs2_fwd_hit & ~(issue_valid & (issue_rd == rs2_addr)));
`else
  assign rs1_busy = rs1_pend;
  assign rs2_busy = rs2_pend;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [2:0]      lsu_pattern;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            rs1_busy, rs2_busy;
  logic            rf_wr_enable;
  logic [4:0]      rf_wr_address;
  logic [XLEN-1:0] rf_wr_data;
  logic [2:0]      rf_write_pattern;
`ifdef REGFILE_WB_BYPASS_EN
  logic            rs1_fwd_hit, rs2_fwd_hit;
  logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREGS(32), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_pattern(lsu_pattern),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .rf_wr_enable(rf_wr_enable), .rf_wr_address(rf_wr_address),
    .rf_wr_data(rf_wr_data), .rf_write_pattern(rf_write_pattern)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Register file the arbiter feeds; commits the effective value the way the real array would.
  logic [31:0] env_rf [32];
  always @(posedge clk)
    if (rf_wr_enable)
      env_rf[rf_wr_address] <= (rf_write_pattern == 3'b100) ? {24'h0, rf_wr_data[7:0]} : rf_wr_data;

  // Reference model: expected write-port contents, pending set, and who won last.
  bit        m_en;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit [2:0]  m_pat;
  bit        m_pend [32];
  bit        m_last_alu;
  bit        g_alu, g_lsu;

  function automatic bit m_hit(input logic [4:0] rs);
    return m_en && m_addr == rs && rs != 5'd0;
  endfunction

  function automatic bit exp_busy(input logic [4:0] rs);
    bit b;
    if (rs == 5'd0) return 1'b0;
    b = m_pend[rs];
`ifdef REGFILE_WB_BYPASS_EN
    if (m_hit(rs) && !(issue_valid && issue_rd == rs)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic cycle();
    #2;
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (reset_n) begin
      if (alu_valid && lsu_valid) begin
        if (m_last_alu) g_lsu = 1'b1; else g_alu = 1'b1;
      end else if (alu_valid) g_alu = 1'b1;
      else if (lsu_valid)     g_lsu = 1'b1;
    end
    check("alu_ready", {31'h0, alu_ready}, {31'h0, g_alu});
    check("lsu_ready", {31'h0, lsu_ready}, {31'h0, g_lsu});
    check("rs1_busy", {31'h0, rs1_busy}, {31'h0, exp_busy(rs1_addr)});
    check("rs2_busy", {31'h0, rs2_busy}, {31'h0, exp_busy(rs2_addr)});
`ifdef REGFILE_WB_BYPASS_EN
    check("rs1_fwd_hit", {31'h0, rs1_fwd_hit}, {31'h0, m_hit(rs1_addr)});
    check("rs2_fwd_hit", {31'h0, rs2_fwd_hit}, {31'h0, m_hit(rs2_addr)});
    check("rs1_fwd_data", rs1_fwd_data, (m_pat == 3'b100) ? {24'h0, m_data[7:0]} : m_data);
`endif
    @(posedge clk);
    if (!reset_n) begin
      m_en = 0; m_addr = 0; m_data = 0; m_pat = 0; m_last_alu = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      if (m_en) m_pend[m_addr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
      if (g_alu) begin
        m_en = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data; m_pat = 3'b000; m_last_alu = 1'b1;
      end else if (g_lsu) begin
        m_en = (lsu_rd != 0); m_addr = lsu_rd; m_data = lsu_data; m_pat = lsu_pattern; m_last_alu = 1'b0;
      end else m_en = 1'b0;
    end
    #1;
    check("rf_wr_enable", {31'h0, rf_wr_enable}, {31'h0, m_en});
    check("rf_wr_address", {27'h0, rf_wr_address}, {27'h0, m_addr});
    check("rf_wr_data", rf_wr_data, m_data);
    check("rf_write_pattern", {29'h0, rf_write_pattern}, {29'h0, m_pat});
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
  endtask

  initial begin
    reset_n = 0; idle();
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h1;
    lsu_rd = 0; lsu_data = 0; lsu_pattern = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    @(posedge clk); #1;

    // Reset held with a live ALU request
    cycle();
    cycle();
    check("reset_busy", {31'h0, rs1_busy | rs2_busy}, 32'h0);
    reset_n = 1; lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 32'h66;
    cycle();
    check("first_grant_addr", {27'h0, rf_wr_address}, 32'd4);
    alu_valid = 0;
    cycle();
    idle();
    cycle();

    // Single ALU write with RAW tracking
    issue_valid = 1; issue_rd = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd6;
    cycle();
    issue_valid = 0; alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    check("alu_wr_data", rf_wr_data, 32'hDEADBEEF);
    alu_valid = 0;
    cycle();
    cycle();
    check("rs1_cleared", {31'h0, rs1_busy}, 32'h0);

    // Contention alternates grants
    alu_valid = 1; alu_rd = 5'd1; alu_data = $urandom;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = $urandom; lsu_pattern = 3'b000;
    repeat (4) cycle();
    idle();
    cycle();

    // LBU zero-extend
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'hFFFFFF80; lsu_pattern = 3'b100;
    cycle();
    check("lbu_pattern", {29'h0, rf_write_pattern}, 32'd4);
    lsu_valid = 0;
    cycle();
    cycle();
    check("lbu_rf7", env_rf[7], 32'h00000080);

    // Write to x0 consumes a grant but writes nothing
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hABCD;
    cycle();
    check("x0_no_write", {31'h0, rf_wr_enable}, 32'h0);

    // Set/clear collision on register 3
    alu_rd = 5'd3; alu_data = 32'h33;
    cycle();
    alu_valid = 0; issue_valid = 1; issue_rd = 5'd3; rs1_addr = 5'd3;
    cycle();
    issue_valid = 0;
    #1 check("set_wins", {31'h0, rs1_busy}, 32'h1);
    cycle();

`ifdef REGFILE_WB_BYPASS_EN
    issue_valid = 1; issue_rd = 5'd9;
    cycle();
    issue_valid = 0; alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h12345678;
    cycle();
    alu_valid = 0; rs1_addr = 5'd9;
    #1;
    check("byp_hit", {31'h0, rs1_fwd_hit}, 32'h1);
    check("byp_data", rs1_fwd_data, 32'h12345678);
    check("byp_busy", {31'h0, rs1_busy}, 32'h0);
    cycle();
`endif

    // Random traffic with hold-until-ready requesters and occasional reset
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid && $urandom_range(0, 2) == 0) begin
        alu_valid = 1; alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!lsu_valid && $urandom_range(0, 2) == 0) begin
        lsu_valid = 1; lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
        lsu_pattern = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'($urandom_range(0, 7));
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = 5'($urandom_range(0, 31));
      reset_n     = ($urandom_range(0, 99) != 0);
      cycle();
      if (g_alu) alu_valid = 0;
      if (g_lsu) lsu_valid = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
